// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants for the pipelined carry-lookahead adder:
//   DEF_WIDTH / DEF_BLK : default operand width and bits per lookahead block
//   OP_ADD / OP_SUB     : encoding of the op_sub input
//   signed_ovf()        : signed overflow from the MSB column of a sum
// -----------------------------------------------------------------------------
package cla_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLK   = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // The carry into the MSB equals x^y^s at that bit, so overflow is that
   // carry XOR the carry out of the MSB.
   function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                       input logic s_msb, input logic c_msb_out);
      return x_msb ^ y_msb ^ s_msb ^ c_msb_out;
   endfunction

endpackage

// File: rtl/cla_block_n.sv
// -----------------------------------------------------------------------------
// cla_block_n
// Combinational BLK-bit carry-lookahead block. Every internal carry is
// formed directly from the generate/propagate terms and c_in, so there is
// no ripple chain inside the block.
// Ports:
//   x, y   in  [BLK-1:0]  operand slices
//   c_in   in  1          carry into bit 0 of the block
//   s      out [BLK-1:0]  block sum
//   c_out  out 1          carry out of the top bit of the block
//   P, G   out 1          group propagate / group generate
// -----------------------------------------------------------------------------
module cla_block_n #(
   parameter int BLK = 8
) (
   input  logic [BLK-1:0] x,
   input  logic [BLK-1:0] y,
   input  logic           c_in,
   output logic [BLK-1:0] s,
   output logic           c_out,
   output logic           P,
   output logic           G
);

   logic [BLK-1:0] p;
   logic [BLK-1:0] g;
   logic [BLK:0]   c;
   logic           acc;
   logic           run;
   logic           grp_g;

   assign p = x ^ y;
   assign g = x & y;

   // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
   always_comb begin
      c     = '0;
      acc   = 1'b0;
      run   = 1'b1;
      grp_g = 1'b0;
      c[0]  = c_in;
      for (int i = 0; i < BLK; i++) begin
         acc = 1'b0;
         run = 1'b1;
         for (int j = i; j >= 0; j--) begin
            acc = acc | (run & g[j]);
            run = run & p[j];
         end
         // the last iteration leaves the whole-block generate term in acc
         grp_g  = acc;
         c[i+1] = acc | (run & c_in);
      end
   end

   assign s     = p ^ c[BLK-1:0];
   assign c_out = c[BLK];
   assign P     = &p;
   assign G     = grp_g;

endmodule

// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
// Pipelined add/subtract unit. Block k of the operands is resolved in stage k
// by a cla_block_n; the block carry, the untouched upper operand bits and the
// finished lower sum bits travel forward in per-stage registers. Each stage
// has its own valid bit and loads when empty or when its content moves on in
// the same cycle, so bubbles collapse and a full pipe streams one beat/cycle.
// Optional feature macro: CLA_ADDER_PIPE_FLAGS_EN (ovf/zero flags; when
// undefined both flags are tied to 0 and no flag registers exist).
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      beat accepted when in_valid && in_ready
//   x, y       in   WIDTH  operands
//   c_in       in   1      carry-in (add only)
//   op_sub     in   1      0 = add, 1 = subtract
//   out_valid  out  1      result beat present
//   out_ready  in   1      result consumed when out_valid && out_ready
//   s          out  WIDTH  sum / difference
//   c_out      out  1      carry out of bit WIDTH-1
//   ovf, zero  out  1      signed overflow, all-zero result
// -----------------------------------------------------------------------------
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLK   = DEF_BLK
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int NBLK = WIDTH / BLK;
   localparam int LAST = NBLK - 1;

   logic [NBLK-1:0] valid;
   logic [NBLK-1:0] space;
   logic [NBLK-1:0] adv;
   logic [NBLK-1:0] ld;
   logic            ready_next;

   // Backpressure walks from the output towards the input: a stage can take
   // new content when it is empty or its current beat moves on.
   always_comb begin
      adv        = '0;
      space      = '0;
      ld         = '0;
      ready_next = out_ready;
      for (int k = NBLK - 1; k >= 0; k--) begin
         adv[k]     = valid[k] & ready_next;
         space[k]   = ~valid[k] | (valid[k] & ready_next);
         ready_next = ~valid[k] | (valid[k] & ready_next);
      end
      ld[0] = space[0] & in_valid;
      for (int k = 1; k < NBLK; k++) begin
         ld[k] = space[k] & valid[k-1];
      end
   end

   // Stage occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
      end else begin
         valid <= ld | (valid & ~adv);
      end
   end

   assign in_ready  = space[0];
   assign out_valid = valid[LAST];

   for (genvar k = 0; k < NBLK; k++) begin : g_stage
      localparam int IW = WIDTH - k * BLK;   // operand bits still to resolve
      localparam int SW = (k + 1) * BLK;     // sum bits known after this stage

      logic [IW-1:0]  xi;
      logic [IW-1:0]  yi;
      logic           ci;
      logic [BLK-1:0] bs;
      logic           bco;
      logic           bp;
      logic           bg;
      logic [SW-1:0]  sn;
      logic           unused_pg;

      if (k == 0) begin : g_in
         // subtract is x + ~y + 1; c_in only matters for add
         assign xi = x;
         assign yi = (op_sub == OP_SUB) ? ~y : y;
         assign ci = (op_sub == OP_ADD) ? c_in : 1'b1;
         assign sn = bs;
      end else begin : g_fwd
         assign xi = g_stage[k-1].g_reg.xr;
         assign yi = g_stage[k-1].g_reg.yr;
         assign ci = g_stage[k-1].g_reg.cr;
         assign sn = {bs, g_stage[k-1].g_reg.sr};
      end

      cla_block_n #(.BLK(BLK)) u_blk (
         .x     (xi[BLK-1:0]),
         .y     (yi[BLK-1:0]),
         .c_in  (ci),
         .s     (bs),
         .c_out (bco),
         .P     (bp),
         .G     (bg)
      );

      // the stage carry is taken from c_out; group P/G are not needed here
      assign unused_pg = bp ^ bg;

      if (k < NBLK - 1) begin : g_reg
         logic [IW-BLK-1:0] xr;
         logic [IW-BLK-1:0] yr;
         logic [SW-1:0]     sr;
         logic              cr;

         // Stage register: remaining operand bits, finished sum bits, carry.
         always_ff @(posedge clock) begin
            if (reset) begin
               xr <= '0;
               yr <= '0;
               sr <= '0;
               cr <= 1'b0;
            end else if (ld[k]) begin
               xr <= xi[IW-1:BLK];
               yr <= yi[IW-1:BLK];
               sr <= sn;
               cr <= bco;
            end
         end
      end
   end

   // Output register: only reloads on a new beat, so it holds otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         s     <= '0;
         c_out <= 1'b0;
      end else if (ld[LAST]) begin
         s     <= g_stage[LAST].sn;
         c_out <= g_stage[LAST].bco;
      end
   end

`ifdef CLA_ADDER_PIPE_FLAGS_EN
   logic ovf_n;
   logic zero_n;

   assign ovf_n  = signed_ovf(g_stage[LAST].xi[BLK-1], g_stage[LAST].yi[BLK-1],
                              g_stage[LAST].bs[BLK-1], g_stage[LAST].bco);
   assign zero_n = (g_stage[LAST].sn == {WIDTH{1'b0}});

   // Flag registers load together with s.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else if (ld[LAST]) begin
         ovf  <= ovf_n;
         zero <= zero_n;
      end
   end
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width; legal values are multiples of BLK.
REQ-002 SHALL have parameter BLK, default 8, bits per lookahead block; NBLK = WIDTH/BLK pipeline stages.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port x, y  input  WIDTH each  operands.
REQ-008 SHALL have port c_in  input  1  carry-in, used for add only.
REQ-009 SHALL have port op_sub  input  1  0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port s  output  WIDTH  sum/difference.
REQ-013 SHALL have port c_out  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf, zero  output  1 each  signed overflow and all-zero result flags.

Function
REQ-015 SHALL compute add as x + y + c_in, and subtract as x + ~y + 1 with c_in ignored.
REQ-016 SHALL resolve block k (bits k*BLK..k*BLK+BLK-1) in pipeline stage k, with full carry lookahead inside the block (p = x^y, g = x&y).
REQ-017 SHALL take the carry-in of stage k from the registered carry-out of stage k-1, and carry upper operand bits and lower result bits forward in registers.
REQ-018 SHALL set latency to exactly NBLK cycles from accept to out_valid when never stalled; throughput SHALL be one beat per cycle.
REQ-019 SHALL give each stage a valid bit; a stage loads when it is empty or its content moves on in the same cycle.
REQ-020 SHALL drive in_ready = !valid[0] || stage 0 advancing, and drive out_valid = valid[NBLK-1].
REQ-021 SHALL, when out_ready = 0 with the pipe full, hold all stage contents and outputs stable, drop in_ready, and lose or duplicate no beat.
REQ-022 SHALL allow accept and retire in the same cycle when full, with out_ready = 1 sustaining full throughput.
REQ-023 SHALL deliver results in acceptance order.
REQ-024 SHALL define ovf = carry into bit WIDTH-1 XOR c_out, and zero = (s == 0).
REQ-025 SHALL hold outputs at their last value, not X, while out_valid = 0.

Reset
REQ-026 SHALL clear every valid bit while reset is high, making out_valid = 0 and in_ready = 1 in the cycle after reset is sampled.
REQ-027 SHALL reset s, c_out, ovf and zero to 0.
REQ-028 SHALL discard in-flight beats on reset mid-operation, and SHALL ignore an input offered during reset.

Configuration
REQ-029 SHALL, with CLA_ADDER_PIPE_FLAGS_EN defined, compute ovf and zero per REQ-024, pipelined with s.
REQ-030 SHALL, without CLA_ADDER_PIPE_FLAGS_EN, tie ovf and zero to 0, keep the ports present, and add no flag registers.

Structure
REQ-031 SHALL place the op encoding constants (OP_ADD = 0, OP_SUB = 1) and the default WIDTH and BLK constants in package cla_pkg.
REQ-032 SHALL implement one sub-module, cla_block_n: a combinational BLK-bit lookahead block with inputs x, y, c_in and outputs s, c_out, P, G, instantiated NBLK times via generate.
REQ-033 SHALL place all sequential logic in cla_adder_pipe.

Verification (WIDTH = 32, BLK = 8)
REQ-034 SHALL check add 0xFFFFFFFF + 0x00000001, c_in = 0 -> after 4 cycles: s = 0x00000000, c_out = 1, zero = 1, ovf = 0.
REQ-035 SHALL check add 0x7FFFFFFF + 0x00000001 -> s = 0x80000000, c_out = 0, ovf = 1 (ovf = 0 without the macro).
REQ-036 SHALL check sub 5 - 7 -> s = 0xFFFFFFFE, c_out = 0, ovf = 0; and sub 7 - 5 -> s = 0x00000002, c_out = 1.
REQ-037 SHALL check 6 back-to-back adds with out_ready = 0 -> in_ready drops after the 4th accept; after out_ready = 1, all 6 results arrive in order with no gaps.
REQ-038 SHALL check reset asserted with 3 beats in flight -> next cycle out_valid = 0, in_ready = 1, and no stale result ever emerges.
REQ-039 SHALL check a random stream of 10k beats with random out_ready -> results match a reference model for s, c_out, ovf and zero.
